// File: rtl/sub_refill_sched.sv
// Refill scheduler for a small set of sub-SRAMs: second-chance victim pick, Flash burst fetch, tag update.
// Latency: miss accept -> fill_done in 1 + up to SUB_NUM+1 scan + 1 evict + grant wait + SUB_DEPTH beats + 1 cycles.
// Backpressure: miss_ready only in IDLE; flash_req held until flash_gnt; Flash beats are accepted without stalling.
module sub_refill_sched #(
  parameter int SUB_NUM     = 4,
  parameter int LOG_SUB_NUM = 2,
  parameter int SUB_DEPTH   = 256,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                         clk,
  input  logic                         grst,
  input  logic                         miss_valid,
  output logic                         miss_ready,
  input  logic [ADDR_W-1:0]            miss_addr,
  input  logic                         hit_valid,
  input  logic [LOG_SUB_NUM-1:0]       hit_idx,
  output logic                         flash_req,
  input  logic                         flash_gnt,
  output logic [ADDR_W-1:0]            flash_addr,
  input  logic                         flash_rvalid,
  input  logic [DATA_W-1:0]            flash_rdata,
  output logic                         sub_we,
  output logic [LOG_SUB_NUM-1:0]       sub_sel,
  output logic [$clog2(SUB_DEPTH)-1:0] sub_waddr,
  output logic [DATA_W-1:0]            sub_wdata,
  output logic                         tag_we,
  output logic [LOG_SUB_NUM-1:0]       tag_idx,
  output logic [ADDR_W-1:0]            tag_base,
  output logic                         tag_valid,
  output logic                         fill_done,
  output logic [LOG_SUB_NUM-1:0]       fill_idx,
  output logic                         busy
);

  localparam int WADDR_W = $clog2(SUB_DEPTH);
  // Byte offset bits inside one block (words are DATA_W/8 bytes wide).
  localparam int OFF_W   = $clog2(SUB_DEPTH * (DATA_W / 8));
  localparam logic [WADDR_W-1:0]     LAST_BEAT = WADDR_W'(SUB_DEPTH - 1);
  localparam logic [LOG_SUB_NUM:0]   SCAN_MAX  = (LOG_SUB_NUM + 1)'(SUB_NUM);
  localparam logic [LOG_SUB_NUM-1:0] PTR_LAST  = LOG_SUB_NUM'(SUB_NUM - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SCAN   = 3'd1;
  localparam logic [2:0] EVICT  = 3'd2;
  localparam logic [2:0] REQ    = 3'd3;
  localparam logic [2:0] FILL   = 3'd4;
  localparam logic [2:0] COMMIT = 3'd5;

  // Control state
  logic [2:0]             state_q, state_d;
  logic [LOG_SUB_NUM-1:0] ptr_q, ptr_d;
  logic [LOG_SUB_NUM-1:0] victim_q, victim_d;
  logic [WADDR_W-1:0]     cnt_q, cnt_d;
  logic [LOG_SUB_NUM:0]   scan_q, scan_d;
  logic [ADDR_W-1:0]      req_base_q, req_base_d;
  logic [SUB_NUM-1:0]     valid_q, valid_d;
  logic [SUB_NUM-1:0]     ref_q, ref_d;
  logic [ADDR_W-1:0]      base_q [SUB_NUM];
  logic [ADDR_W-1:0]      base_d [SUB_NUM];

  // Registered outputs
  logic                   miss_ready_q, miss_ready_d;
  logic                   busy_q, busy_d;
  logic                   flash_req_q, flash_req_d;
  logic [ADDR_W-1:0]      flash_addr_q, flash_addr_d;
  logic                   sub_we_q, sub_we_d;
  logic [LOG_SUB_NUM-1:0] sub_sel_q, sub_sel_d;
  logic [WADDR_W-1:0]     sub_waddr_q, sub_waddr_d;
  logic [DATA_W-1:0]      sub_wdata_q, sub_wdata_d;
  logic                   tag_we_q, tag_we_d;
  logic [LOG_SUB_NUM-1:0] tag_idx_q, tag_idx_d;
  logic [ADDR_W-1:0]      tag_base_q, tag_base_d;
  logic                   tag_valid_q, tag_valid_d;
  logic                   fill_done_q, fill_done_d;
  logic [LOG_SUB_NUM-1:0] fill_idx_q, fill_idx_d;

  logic                   victim_lock;
  logic                   unused_addr_bits;

  // Offset bits within the block never matter: the whole block is refilled.
  assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

  function automatic logic [LOG_SUB_NUM-1:0] ptr_inc(input logic [LOG_SUB_NUM-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Next-state logic for the FSM, replacement tables and all outputs
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    victim_d     = victim_q;
    cnt_d        = cnt_q;
    scan_d       = scan_q;
    req_base_d   = req_base_q;
    valid_d      = valid_q;
    ref_d        = ref_q;
    base_d       = base_q;
    sub_we_d     = 1'b0;
    sub_sel_d    = sub_sel_q;
    sub_waddr_d  = sub_waddr_q;
    sub_wdata_d  = sub_wdata_q;
    tag_we_d     = 1'b0;
    tag_idx_d    = tag_idx_q;
    tag_base_d   = tag_base_q;
    tag_valid_d  = tag_valid_q;
    fill_done_d  = 1'b0;
    fill_idx_d   = fill_idx_q;
    victim_lock  = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_valid && miss_ready_q) begin
          req_base_d = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          scan_d     = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // After SUB_NUM clears the entry at ptr is taken unconditionally, so a
        // stream of hits re-arming ref bits cannot stretch the scan.
        if (!valid_q[ptr_q] || !ref_q[ptr_q] || (scan_q == SCAN_MAX)) begin
          victim_d    = ptr_q;
          tag_we_d    = 1'b1;
          tag_idx_d   = ptr_q;
          tag_valid_d = 1'b0;
          tag_base_d  = base_q[ptr_q];
          state_d     = EVICT;
        end else begin
          ref_d[ptr_q] = 1'b0;
          ptr_d        = ptr_inc(ptr_q);
          scan_d       = scan_q + 1'b1;
        end
      end
      EVICT: begin
        victim_lock      = 1'b1;
        valid_d[victim_q] = 1'b0;
        state_d          = REQ;
      end
      REQ: begin
        victim_lock = 1'b1;
        if (flash_gnt) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        victim_lock = 1'b1;
        if (flash_rvalid) begin
          sub_we_d    = 1'b1;
          sub_sel_d   = victim_q;
          sub_waddr_d = cnt_q;
          sub_wdata_d = flash_rdata;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            // Commit pulses are launched here so they are visible during COMMIT.
            tag_we_d    = 1'b1;
            tag_idx_d   = victim_q;
            tag_valid_d = 1'b1;
            tag_base_d  = req_base_q;
            fill_done_d = 1'b1;
            fill_idx_d  = victim_q;
            state_d     = COMMIT;
          end
        end
      end
      COMMIT: begin
        victim_lock       = 1'b1;
        valid_d[victim_q] = 1'b1;
        base_d[victim_q]  = req_base_q;
        ref_d[victim_q]   = 1'b1;
        ptr_d             = ptr_inc(victim_q);
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Applied after the scan clear so a coincident hit keeps the entry referenced.
    if (hit_valid && !(victim_lock && (hit_idx == victim_q))) begin
      ref_d[hit_idx] = 1'b1;
    end

    miss_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    flash_req_d  = (state_d == REQ);
    flash_addr_d = req_base_d;
  end

  // State and output registers, all cleared asynchronously
  always_ff @(posedge clk or negedge grst) begin
    if (!grst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      victim_q     <= '0;
      cnt_q        <= '0;
      scan_q       <= '0;
      req_base_q   <= '0;
      valid_q      <= '0;
      ref_q        <= '0;
      for (int i = 0; i < SUB_NUM; i++) base_q[i] <= '0;
      miss_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      flash_req_q  <= 1'b0;
      flash_addr_q <= '0;
      sub_we_q     <= 1'b0;
      sub_sel_q    <= '0;
      sub_waddr_q  <= '0;
      sub_wdata_q  <= '0;
      tag_we_q     <= 1'b0;
      tag_idx_q    <= '0;
      tag_base_q   <= '0;
      tag_valid_q  <= 1'b0;
      fill_done_q  <= 1'b0;
      fill_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      victim_q     <= victim_d;
      cnt_q        <= cnt_d;
      scan_q       <= scan_d;
      req_base_q   <= req_base_d;
      valid_q      <= valid_d;
      ref_q        <= ref_d;
      base_q       <= base_d;
      miss_ready_q <= miss_ready_d;
      busy_q       <= busy_d;
      flash_req_q  <= flash_req_d;
      flash_addr_q <= flash_addr_d;
      sub_we_q     <= sub_we_d;
      sub_sel_q    <= sub_sel_d;
      sub_waddr_q  <= sub_waddr_d;
      sub_wdata_q  <= sub_wdata_d;
      tag_we_q     <= tag_we_d;
      tag_idx_q    <= tag_idx_d;
      tag_base_q   <= tag_base_d;
      tag_valid_q  <= tag_valid_d;
      fill_done_q  <= fill_done_d;
      fill_idx_q   <= fill_idx_d;
    end
  end

  assign miss_ready = miss_ready_q;
  assign busy       = busy_q;
  assign flash_req  = flash_req_q;
  assign flash_addr = flash_addr_q;
  assign sub_we     = sub_we_q;
  assign sub_sel    = sub_sel_q;
  assign sub_waddr  = sub_waddr_q;
  assign sub_wdata  = sub_wdata_q;
  assign tag_we     = tag_we_q;
  assign tag_idx    = tag_idx_q;
  assign tag_base   = tag_base_q;
  assign tag_valid  = tag_valid_q;
  assign fill_done  = fill_done_q;
  assign fill_idx   = fill_idx_q;

endmodule

// File: tb/tb_sub_refill_sched.sv
module tb_sub_refill_sched;

  logic        clk = 1'b0;
  logic        grst;
  logic        miss_valid, miss_ready;
  logic [31:0] miss_addr;
  logic        hit_valid;
  logic [1:0]  hit_idx;
  logic        flash_req, flash_gnt;
  logic [31:0] flash_addr;
  logic        flash_rvalid;
  logic [31:0] flash_rdata;
  logic        sub_we;
  logic [1:0]  sub_sel;
  logic [7:0]  sub_waddr;
  logic [31:0] sub_wdata;
  logic        tag_we;
  logic [1:0]  tag_idx;
  logic [31:0] tag_base;
  logic        tag_valid;
  logic        fill_done;
  logic [1:0]  fill_idx;
  logic        busy;

  always #5 clk = ~clk;

  sub_refill_sched dut (
    .clk(clk), .grst(grst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .hit_valid(hit_valid), .hit_idx(hit_idx),
    .flash_req(flash_req), .flash_gnt(flash_gnt), .flash_addr(flash_addr),
    .flash_rvalid(flash_rvalid), .flash_rdata(flash_rdata),
    .sub_we(sub_we), .sub_sel(sub_sel), .sub_waddr(sub_waddr), .sub_wdata(sub_wdata),
    .tag_we(tag_we), .tag_idx(tag_idx), .tag_base(tag_base), .tag_valid(tag_valid),
    .fill_done(fill_done), .fill_idx(fill_idx), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Beat data: fill number, a marker byte, inverted and plain beat index.
  function automatic logic [31:0] pat(input int f, input int i);
    logic [31:0] fv, iv;
    fv = f;
    iv = i;
    return {fv[7:0], 8'h5A, ~iv[7:0], iv[7:0]};
  endfunction

  // Write-port monitor: every write must land on the expected entry, in order.
  int         wr_count = 0;
  int         wr_bad   = 0;
  int         wr_base  = 0;
  int         cur_fill = 0;
  logic [1:0] exp_sel  = 2'd0;
  bit         hold_en  = 1'b0;
  logic [31:0] hold_addr = 32'h0;
  bit         fill_hits = 1'b0;

  always @(negedge clk) begin
    if (sub_we === 1'b1) begin
      int idx;
      idx = wr_count - wr_base;
      if (sub_sel !== exp_sel || sub_waddr !== idx[7:0] || sub_wdata !== pat(cur_fill, idx))
        wr_bad++;
      wr_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One complete miss: accept, scan, evict, request, fill (nbeats < 256 stops early).
  task automatic do_miss(input logic [31:0] addr, input logic [1:0] vic, input int scan_exp,
                         input logic [31:0] old_base, input int gnt_wait, input int nbeats,
                         input bit scan_hit, input logic [1:0] scan_hit_idx);
    int n;
    bit ok;
    logic [31:0] blk;
    blk = {addr[31:10], 10'b0};
    cur_fill = cur_fill + 1;
    wr_base  = wr_count;
    exp_sel  = vic;

    miss_addr  = addr;
    miss_valid = 1'b1;
    n = 0;
    while (miss_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("miss_accept", miss_ready, 1);
    @(posedge clk); #1;
    miss_valid = 1'b0;
    hit_valid  = scan_hit;
    hit_idx    = scan_hit_idx;
    @(posedge clk); #1;
    hit_valid  = 1'b0;

    n = 0;
    do begin @(negedge clk); n++; end while (tag_we !== 1'b1 && n < 10);
    check("scan_cycles", n, scan_exp);
    check("evict_tag_we", tag_we, 1);
    check("evict_tag_idx", tag_idx, vic);
    check("evict_tag_valid", tag_valid, 0);
    check("evict_tag_base", tag_base, old_base);

    n = 0;
    do begin @(negedge clk); n++; end while (flash_req !== 1'b1 && n < 10);
    check("req_delay", n, 1);
    check("flash_addr", flash_addr, blk);
    check("req_busy", busy, 1);

    ok = 1'b1;
    for (int k = 0; k < gnt_wait; k++) begin
      @(negedge clk);
      if (!(flash_req === 1'b1 && flash_addr === blk && busy === 1'b1 &&
            wr_count == wr_base && tag_we === 1'b0)) ok = 1'b0;
    end
    if (gnt_wait > 0) check("gnt_wait_hold", ok, 1);

    flash_gnt = 1'b1;
    @(posedge clk); #1;
    flash_gnt = 1'b0;

    for (int i = 0; i < nbeats; i++) begin
      if (hold_en && i == 0) begin
        miss_valid = 1'b1;
        miss_addr  = hold_addr;
      end
      if (i == 128) check("miss_ready_in_fill", miss_ready, 0);
      flash_rvalid = 1'b1;
      flash_rdata  = pat(cur_fill, i);
      hit_valid    = fill_hits && (i == 50 || i == 51);
      hit_idx      = (i == 50) ? 2'd1 : 2'd2;
      @(posedge clk); #1;
      flash_rvalid = 1'b0;
      hit_valid    = 1'b0;
      if (i % 64 == 63 && i != nbeats - 1) begin
        @(posedge clk); #1;
      end
    end

    if (nbeats < 256) begin
      @(negedge clk);
    end else begin
      n = 0;
      do begin @(negedge clk); n++; end while (fill_done !== 1'b1 && n < 10);
      check("fill_done_delay", n, 1);
      check("fill_idx", fill_idx, vic);
      check("commit_tag_we", tag_we, 1);
      check("commit_tag_idx", tag_idx, vic);
      check("commit_tag_valid", tag_valid, 1);
      check("commit_tag_base", tag_base, blk);
      check("miss_ready_commit", miss_ready, 0);
      @(negedge clk);
      check("write_count", wr_count - wr_base, 256);
      check("write_bad", wr_bad, 0);
      check("idle_miss_ready", miss_ready, 1);
      check("idle_busy", busy, 0);
      check("fill_done_pulse", fill_done, 0);
    end
  endtask

  initial begin
    int snap;
    grst = 1'b1; miss_valid = 1'b0; miss_addr = '0; hit_valid = 1'b0; hit_idx = '0;
    flash_gnt = 1'b0; flash_rvalid = 1'b0; flash_rdata = '0;
    #1 grst = 1'b0;
    #11;
    check("rst_miss_ready", miss_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_flash_req", flash_req, 0);
    check("rst_sub_we", sub_we, 0);
    check("rst_tag_we", tag_we, 0);
    check("rst_fill_done", fill_done, 0);
    @(negedge clk); grst = 1'b1;
    @(negedge clk);
    check("rel_miss_ready", miss_ready, 1);
    check("rel_busy", busy, 0);

    // Cold fills, one per empty entry in pointer order.
    do_miss(32'h0000_1234, 2'd0, 1, 32'h0, 0, 256, 1'b0, 2'd0);
    do_miss(32'h0000_2000, 2'd1, 1, 32'h0, 0, 256, 1'b0, 2'd0);
    do_miss(32'h0000_3000, 2'd2, 1, 32'h0, 0, 256, 1'b0, 2'd0);
    // Hits on 1 and 2 during the fill; next miss held pending throughout the fill.
    hold_en = 1'b1; hold_addr = 32'h0000_5000; fill_hits = 1'b1;
    do_miss(32'h0000_4000, 2'd3, 1, 32'h0, 0, 256, 1'b0, 2'd0);
    hold_en = 1'b0; fill_hits = 1'b0;
    // All referenced: full second-chance sweep returns to entry 0; grant withheld 10 cycles.
    do_miss(32'h0000_5000, 2'd0, 5, 32'h0000_1000, 10, 256, 1'b0, 2'd0);

    @(posedge clk); #1; hit_valid = 1'b1; hit_idx = 2'd1;
    @(posedge clk); #1; hit_valid = 1'b0;
    @(negedge clk);
    // Hit on entry 1 in the very cycle the scan clears it: entry 1 skipped, 2 chosen.
    do_miss(32'h0000_6000, 2'd2, 2, 32'h0000_3000, 0, 256, 1'b1, 2'd1);
    do_miss(32'h0000_7000, 2'd3, 1, 32'h0000_4000, 0, 256, 1'b0, 2'd0);
    // Entry 1 kept its ref bit, so this sweep goes all the way round.
    do_miss(32'h0000_8000, 2'd0, 5, 32'h0000_5000, 0, 256, 1'b0, 2'd0);
    // Abort mid-burst at beat 100.
    do_miss(32'h0000_9000, 2'd1, 1, 32'h0000_2000, 0, 100, 1'b0, 2'd0);
    #2;
    check("abort_writes", wr_count - wr_base, 100);
    grst = 1'b0;
    #1;
    check("arst_miss_ready", miss_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_flash_req", flash_req, 0);
    check("arst_sub_we", sub_we, 0);
    check("arst_flash_addr", flash_addr, 0);
    check("arst_tag_we", tag_we, 0);
    @(negedge clk);
    @(negedge clk); grst = 1'b1;
    snap = wr_count;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      flash_rvalid = 1'b1;
      flash_rdata  = 32'hDEAD_0000 + i;
    end
    @(posedge clk); #1;
    flash_rvalid = 1'b0;
    @(negedge clk);
    check("stray_beats", wr_count - snap, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_miss_ready", miss_ready, 1);
    // Tables cleared: entry 0 taken immediately with an all-zero old tag.
    do_miss(32'h0000_A3FC, 2'd0, 1, 32'h0, 0, 256, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sub_refill_sched.md
SUB_REFILL_SCHED -- requirements
Module: sub_refill_sched

Interface
REQ-001 Parameter SUB_NUM, 4, number of sub-SRAMs; LOG_SUB_NUM, 2, index width.
REQ-002 Parameter SUB_DEPTH, 256, words per sub-SRAM; block = SUB_DEPTH*4 bytes = 1 KiB.
REQ-003 Parameter ADDR_W, 32 and DATA_W, 32: byte-address width and data width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 grst  in  1  reset, asynchronous, active-low.
REQ-006 miss_valid / miss_ready  in / out  1 / 1  sub-SRAM read-miss request handshake.
REQ-007 miss_addr  in  32  missing byte address.
REQ-008 hit_valid / hit_idx  in  1 / 2  sub-SRAM hit notification and entry index.
REQ-009 flash_req / flash_gnt  out / in  1 / 1  Flash burst request handshake.
REQ-010 flash_addr  out  32  burst start byte address.
REQ-011 flash_rvalid / flash_rdata  in  1 / 32  Flash read beat.
REQ-012 sub_we / sub_sel / sub_waddr / sub_wdata  out  1 / 2 / 8 / 32  sub-SRAM write port.
REQ-013 tag_we / tag_idx / tag_base / tag_valid  out  1 / 2 / 32 / 1  address-tag table update.
REQ-014 fill_done / fill_idx  out  1 / 2  one-cycle completion pulse and filled entry.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The block SHALL hold per-entry valid[i], ref[i] and base[i] registers and a 2-bit victim pointer ptr.
REQ-017 FSM states SHALL be IDLE, SCAN, EVICT, REQ, FILL, COMMIT.
REQ-018 miss_ready SHALL be 1 only in IDLE; a request SHALL be accepted when miss_valid & miss_ready, latching base = {miss_addr[31:10],10'b0}, next state SCAN.
REQ-019 SCAN SHALL evaluate one entry per cycle at ptr: if valid=0 or ref=0, victim=ptr and go to EVICT; otherwise clear ref[ptr], ptr wraps 3->0, stay in SCAN.
REQ-020 SCAN SHALL complete within SUB_NUM+1 cycles.
REQ-021 EVICT SHALL pulse tag_we for one cycle with tag_idx=victim, tag_valid=0, tag_base=base[victim], and clear valid[victim]; then go to REQ.
REQ-022 REQ SHALL hold flash_req=1, flash_addr=latched base until flash_gnt=1; then go to FILL with word counter cnt=0.
REQ-023 In FILL each flash_rvalid SHALL produce, on the next cycle, sub_we=1, sub_sel=victim, sub_waddr=cnt, sub_wdata=rdata; cnt increments by 1 (8-bit).
REQ-024 The beat with cnt=255 SHALL move the FSM to COMMIT; flash_rvalid outside FILL SHALL be ignored.
REQ-025 COMMIT SHALL pulse tag_we with tag_valid=1, tag_base=latched base, tag_idx=victim; set valid[victim]=1, base[victim]=base, ref[victim]=1; ptr=victim+1 (wrap); pulse fill_done with fill_idx=victim; return to IDLE.
REQ-026 A miss-to-fill_done latency SHALL be at most 1+(SUB_NUM+1)+1+grant wait+256 beats+2 cycles.
REQ-027 hit_valid SHALL set ref[hit_idx] in any state; when it coincides with a SCAN clear of the same entry, set wins.
REQ-028 hit_valid addressing the victim from EVICT through COMMIT SHALL be ignored.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs except none.

Reset
REQ-030 grst low SHALL immediately force IDLE, ptr=0, cnt=0, all valid/ref/base=0.
REQ-031 During reset: miss_ready=0, busy=0; all other outputs=0; after release miss_ready=1 on the first edge.
REQ-032 Reset mid-fill SHALL abandon the burst; subsequent stray flash_rvalid SHALL produce no sub_we.

Verification
REQ-033 After reset, miss 0x0000_1234 -> EVICT tag_we idx0 valid0; flash_addr=0x0000_1000; 256 writes sub_sel=0 waddr 0..255; COMMIT tag_base=0x0000_1000 idx0; fill_done idx0.
REQ-034 Fill all 4 entries, hit idx1 and idx2, ptr=0 with ref={1,1,1,1} cleared only by scans -> next miss victim picks first ref=0 entry per second-chance order, scan cycles <= 5.
REQ-035 flash_gnt withheld 10 cycles -> flash_req stays 1, flash_addr stable, no sub_we, busy=1.
REQ-036 hit_valid on entry under SCAN clear in same cycle -> ref stays 1, entry skipped.
REQ-037 grst low at beat 100 -> all outputs 0 immediately; later rvalid beats -> no sub_we; next miss refills with ptr=0.
REQ-038 miss_valid held during FILL -> miss_ready=0, second request accepted only in the cycle after fill_done.
